fp_norm_sequencer: RTL and testbench
====================================

FP_NORM_SEQUENCER -- requirements
Module: fp_norm_sequencer

Interface
REQ-001 Parameter SizeMantissa, default 23, stored fraction width; the internal mantissa is SizeMantissa+2 bits (carry bit, hidden bit, fraction).
REQ-002 Parameter SizeExponent, default 8, biased exponent width.
REQ-003 Parameter StepShift, default 4, maximum left-shift distance per cycle (1..SizeMantissa).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 start_i  input  1  request; sampled only in IDLE.
REQ-007 mantissa_i  input  SizeMantissa+2  unnormalized mantissa from add/sub datapath; bit SizeMantissa+1 is carry.
REQ-008 exponent_i  input  SizeExponent  exponent paired with mantissa_i.
REQ-009 busy_o  output  1  high whenever state is not IDLE.
REQ-010 done_o  output  1  one-cycle pulse, result valid.
REQ-011 mantissa_o  output  SizeMantissa+2  normalized mantissa, held until next accepted start.
REQ-012 exponent_o  output  SizeExponent  adjusted exponent, held likewise.
REQ-013 shift_total_o  output  $clog2(SizeMantissa+2)+1  total left shift applied.
REQ-014 zero_o, underflow_o, overflow_o  output  1 each  result flags, held likewise.

Function
REQ-015 FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-016 IDLE with start_i=1: latch inputs, clear shift_total and flags, next state per REQ-017..019; start_i=0: remain IDLE.
REQ-017 Load, mantissa_i all zero: mantissa 0, exponent 0, zero_o=1, next DONE.
REQ-018 Load, mantissa_i[SizeMantissa+1]=1: mantissa = mantissa_i>>1, exponent = exponent_i+1; if result is all ones, overflow_o=1 and next DONE, else next DONE (already normalized).
REQ-019 Load otherwise: mantissa/exponent = inputs, next SHIFT.
REQ-020 SHIFT each cycle: lz = count of zero bits from bit SizeMantissa downward to first 1; step = min(lz, StepShift, exponent_r-1), with exponent_r<=1 giving step 0.
REQ-021 SHIFT, step>0: mantissa <<= step, exponent -= step, shift_total += step, stay SHIFT.
REQ-022 SHIFT, step=0: next DONE; underflow_o=1 iff mantissa[SizeMantissa]=0 (exponent floor reached).
REQ-023 DONE: done_o=1 for exactly that cycle, next IDLE unconditionally.
REQ-024 start_i while busy_o=1 (including DONE) is ignored, not queued.
REQ-025 Latency, start edge to done_o: 2 cycles for zero/carry/already-normalized inputs; otherwise 2 + ceil(L/StepShift) cycles, L = shift actually applied.
REQ-026 Exponent never wraps: decrement limited so exponent_o >= 1 for nonzero results.

Reset
REQ-027 rst_n=0 at any edge, including mid-SHIFT: next state IDLE; busy_o, done_o, mantissa_o, exponent_o, shift_total_o, all flags = 0.
REQ-028 rst_n=0 and start_i=1 same edge: reset wins, request dropped.

Verification (defaults)
REQ-029 mantissa_i=0x0000001, exponent_i=100, start 1 cycle -> SHIFT cycles 1-7 (shifts 4,4,4,4,4,3,0), done_o in cycle 8, mantissa_o=0x0800000, exponent_o=77, shift_total_o=23.
REQ-030 mantissa_i=0x1000000 (carry), exponent_i=100 -> done_o cycle 2, mantissa_o=0x0800000, exponent_o=101, shift_total_o=0.
REQ-031 mantissa_i=0x0000001, exponent_i=5 -> one shift of 4 then stop; mantissa_o=0x0000010, exponent_o=1, underflow_o=1, done_o cycle 3.
REQ-032 mantissa_i=0 -> zero_o=1, exponent_o=0, done_o cycle 2; mantissa_i=0x1000000, exponent_i=254 -> overflow_o=1, exponent_o=255.
REQ-033 start during SHIFT with different operands -> ignored, first result unchanged; rst_n low in SHIFT cycle 3 -> IDLE and all outputs 0 next cycle, no done_o.

Source files
------------

// File: rtl/fp_norm_sequencer.sv
// rtl/fp_norm_sequencer.sv - multi-cycle mantissa normalizer with bounded per-cycle left shift
module fp_norm_sequencer #(
  parameter int SizeMantissa = 23,
  parameter int SizeExponent = 8,
  parameter int StepShift    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [SizeMantissa+1:0]           mantissa_i,
  input  logic [SizeExponent-1:0]           exponent_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [SizeMantissa+1:0]           mantissa_o,
  output logic [SizeExponent-1:0]           exponent_o,
  output logic [$clog2(SizeMantissa+2):0]   shift_total_o,
  output logic                              zero_o,
  output logic                              underflow_o,
  output logic                              overflow_o
);

  localparam int MW = SizeMantissa + 2;
  localparam int SW = $clog2(SizeMantissa + 2) + 1;
  localparam int EW = SizeExponent;
  localparam int CW = (EW > SW) ? EW : SW;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   lz;
  logic [SW-1:0]   step;
  logic [CW-1:0]   exp_m1;
  logic [EW:0]     exp_inc;
  logic            exp_sat;
  logic            found;

  // Leading-zero count from the hidden-bit position down to the first set bit
  always_comb begin
    lz    = SW'(SizeMantissa + 1);
    found = 1'b0;
    for (int i = 0; i <= SizeMantissa; i++) begin
      if (!found && mantissa_o[SizeMantissa - i]) begin
        lz    = SW'(i);
        found = 1'b1;
      end
    end
  end

  // Per-cycle shift distance: limited by the step size and by the exponent floor of 1
  always_comb begin
    exp_m1 = CW'(exponent_o) - CW'(1);
    step   = lz;
    if (step > SW'(StepShift)) begin
      step = SW'(StepShift);
    end
    if (exponent_o <= EW'(1)) begin
      step = '0;
    end else if (CW'(step) > exp_m1) begin
      step = SW'(exp_m1);
    end
  end

  // Exponent increment for the carry case, saturating at all ones
  always_comb begin
    exp_inc = {1'b0, exponent_i} + (EW+1)'(1);
    exp_sat = (exp_inc >= {1'b0, {EW{1'b1}}});
  end

  // Sequencer FSM; the working registers double as the held result outputs.
  // Every accepted load passes through one SHIFT evaluation: values that are
  // already normalized (including zero and the carry-adjusted case) settle
  // there with a zero step, which gives the uniform two-cycle minimum latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      mantissa_o    <= '0;
      exponent_o    <= '0;
      shift_total_o <= '0;
      zero_o        <= 1'b0;
      underflow_o   <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state         <= SHIFT;
            busy_o        <= 1'b1;
            shift_total_o <= '0;
            zero_o        <= 1'b0;
            underflow_o   <= 1'b0;
            overflow_o    <= 1'b0;
            if (mantissa_i == '0) begin
              mantissa_o <= '0;
              exponent_o <= '0;
              zero_o     <= 1'b1;
            end else if (mantissa_i[MW-1]) begin
              mantissa_o <= mantissa_i >> 1;
              if (exp_sat) begin
                exponent_o <= {EW{1'b1}};
                overflow_o <= 1'b1;
              end else begin
                exponent_o <= exp_inc[EW-1:0];
              end
            end else begin
              mantissa_o <= mantissa_i;
              exponent_o <= exponent_i;
            end
          end
        end
        SHIFT: begin
          if (step != '0) begin
            mantissa_o    <= mantissa_o << step;
            exponent_o    <= exponent_o - EW'(step);
            shift_total_o <= shift_total_o + step;
          end else begin
            state       <= DONE;
            done_o      <= 1'b1;
            underflow_o <= !mantissa_o[SizeMantissa] && (mantissa_o != '0);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// tb/tb_fp_norm_sequencer.sv - directed self-checking bench for fp_norm_sequencer
module tb_fp_norm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [24:0] mantissa_i;
  logic [7:0]  exponent_i;
  logic        busy_o;
  logic        done_o;
  logic [24:0] mantissa_o;
  logic [7:0]  exponent_o;
  logic [5:0]  shift_total_o;
  logic        zero_o;
  logic        underflow_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  fp_norm_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .mantissa_i    (mantissa_i),
    .exponent_i    (exponent_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .mantissa_o    (mantissa_o),
    .exponent_o    (exponent_o),
    .shift_total_o (shift_total_o),
    .zero_o        (zero_o),
    .underflow_o   (underflow_o),
    .overflow_o    (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Load one operand, wait for done_o, check latency, result and the one-cycle pulse.
  // With poke set, a conflicting start is driven during SHIFT and must be ignored.
  task automatic run_op(input string tag, input logic [24:0] m, input logic [7:0] e,
                        input int want_cyc, input logic [24:0] want_m, input logic [7:0] want_e,
                        input logic [5:0] want_st, input logic want_z, input logic want_u,
                        input logic want_o, input bit poke);
    int cyc;
    @(posedge clk); #1;
    mantissa_i = m;
    exponent_i = e;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 60) begin
      if (poke && cyc == 2) begin
        start_i    = 1'b1;
        mantissa_i = 25'h1000000;
        exponent_i = 8'd3;
      end
      if (poke && cyc == 4) start_i = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(want_cyc));
    check({tag, "_mant"}, 32'(mantissa_o), 32'(want_m));
    check({tag, "_exp"}, 32'(exponent_o), 32'(want_e));
    check({tag, "_st"}, 32'(shift_total_o), 32'(want_st));
    check({tag, "_flags"}, 32'({zero_o, underflow_o, overflow_o}), 32'({want_z, want_u, want_o}));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'({busy_o, done_o}), 32'd0);
    check({tag, "_hold"}, 32'(mantissa_o), 32'(want_m));
  endtask

  initial begin
    rst_n      = 1'b0;
    start_i    = 1'b0;
    mantissa_i = '0;
    exponent_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_done", 32'({busy_o, done_o}), 32'd0);
    check("rst_mant", 32'(mantissa_o), 32'd0);
    check("rst_exp_st", 32'({exponent_o, shift_total_o}), 32'd0);
    check("rst_flags", 32'({zero_o, underflow_o, overflow_o}), 32'd0);
    rst_n = 1'b1;

    run_op("deep",   25'h0000001, 8'd100, 8, 25'h0800000, 8'd77,  6'd23, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("carry",  25'h1000000, 8'd100, 2, 25'h0800000, 8'd101, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    run_op("floor",  25'h0000001, 8'd5,   3, 25'h0000010, 8'd1,   6'd4,  1'b0, 1'b1, 1'b0, 1'b0);
    run_op("zero",   25'h0000000, 8'd77,  2, 25'h0000000, 8'd0,   6'd0,  1'b1, 1'b0, 1'b0, 1'b0);
    run_op("ovf",    25'h1000000, 8'd254, 2, 25'h0800000, 8'd255, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    run_op("norm",   25'h0800000, 8'd50,  2, 25'h0800000, 8'd50,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    run_op("one",    25'h0400000, 8'd10,  3, 25'h0800000, 8'd9,   6'd1,  1'b0, 1'b0, 1'b0, 1'b0);
    run_op("partial",25'h0000100, 8'd10,  5, 25'h0020000, 8'd1,   6'd9,  1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in SHIFT cycle 3 together with a start request
    @(posedge clk); #1;
    mantissa_i = 25'h0000001;
    exponent_i = 8'd100;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy_o), 32'd1);
    rst_n      = 1'b0;
    start_i    = 1'b1;
    mantissa_i = 25'h1000000;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    start_i = 1'b0;
    check("mrst_busy_done", 32'({busy_o, done_o}), 32'd0);
    check("mrst_mant", 32'(mantissa_o), 32'd0);
    check("mrst_exp_st", 32'({exponent_o, shift_total_o}), 32'd0);
    check("mrst_flags", 32'({zero_o, underflow_o, overflow_o}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mrst_dropped", 32'({busy_o, done_o}), 32'd0);

    run_op("after",  25'h1000000, 8'd100, 2, 25'h0800000, 8'd101, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
